// File: rtl/fetch_top.sv
// Instruction fetch: owns the PC and requests instruction memory over req/ready, then fills the IF/ID register.
// Latency: an instruction enters IF/ID on the edge that ends its imem_ready cycle; with zero-wait memory that is one per cycle.
// Backpressure: if_id_write=0 parks one response in a hold buffer and drops imem_req; pc_write&if_id_write gates the PC advance.
module fetch_top #(
   parameter int                    ADDR_SIZE  = 32,
   parameter int                    INSTR_SIZE = 32,
   parameter logic [ADDR_SIZE-1:0]  RESET_PC   = '0,
   parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pc_write,
   input  logic                  if_id_write,
   input  logic                  branch,
   input  logic [ADDR_SIZE-1:0]  branch_target,
   output logic                  imem_req,
   output logic [ADDR_SIZE-1:0]  imem_addr,
   input  logic                  imem_ready,
   input  logic [INSTR_SIZE-1:0] imem_rdata,
   output logic [ADDR_SIZE-1:0]  pc,
   output logic [INSTR_SIZE-1:0] instruction,
   output logic                  valid
);

   // FETCH issues fetch_pc, HOLD parks a response during a decode stall,
   // DRAIN keeps a branch-killed request alive until memory accepts it.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(4);

   state_t                  state;
   logic [ADDR_SIZE-1:0]    fetch_pc;
   logic [ADDR_SIZE-1:0]    drain_addr;
   logic [ADDR_SIZE-1:0]    hold_pc;
   logic [INSTR_SIZE-1:0]   hold_instr;
   logic [ADDR_SIZE-1:0]    pc_plus4;
   logic                    advance;

   // Sequential PC increment wraps naturally modulo 2^ADDR_SIZE.
   assign pc_plus4 = fetch_pc + PC_STEP;

   // Decode should never raise pc_write without if_id_write; requiring both keeps the PC and IF/ID in step.
   assign advance = pc_write & if_id_write;

   // Request side is decoded from state so a redirect can issue its target in the cycle right after the branch.
   // Reset forces the request low in the reset cycle itself, whatever state was left behind.
   always_comb begin
      imem_req  = !reset && (state != S_HOLD);
      imem_addr = (state == S_DRAIN) ? drain_addr : fetch_pc;
   end

   // Fetch FSM together with the PC, hold buffer and registered IF/ID outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         // An outstanding request is simply abandoned; memory tolerates it.
         state       <= S_FETCH;
         fetch_pc    <= RESET_PC;
         drain_addr  <= RESET_PC;
         hold_pc     <= '0;
         hold_instr  <= NOP_INSTR;
         pc          <= '0;
         instruction <= NOP_INSTR;
         valid       <= 1'b0;
      end else if (branch) begin
         // The redirect flushes IF/ID even when decode is stalling, and any
         // buffered response becomes unreachable once we leave HOLD.
         pc          <= '0;
         instruction <= NOP_INSTR;
         valid       <= 1'b0;
         fetch_pc    <= branch_target;
         if ((state == S_FETCH || state == S_DRAIN) && !imem_ready) begin
            // The in-flight request must still complete at its original address.
            // From DRAIN the older killed address is still the one outstanding.
            state <= S_DRAIN;
            if (state == S_FETCH) begin
               drain_addr <= fetch_pc;
            end
         end else begin
            state <= S_FETCH;
         end
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  if (if_id_write) begin
                     pc          <= pc_plus4;
                     instruction <= imem_rdata;
                     valid       <= 1'b1;
                     if (advance) begin
                        fetch_pc <= pc_plus4;
                     end
                  end else begin
                     // Decode is stalled: keep the response and stop requesting.
                     // fetch_pc stays put so HOLD can advance past it on release.
                     hold_pc    <= pc_plus4;
                     hold_instr <= imem_rdata;
                     state      <= S_HOLD;
                  end
               end else if (if_id_write) begin
                  pc          <= '0;
                  instruction <= NOP_INSTR;
                  valid       <= 1'b0;
               end
            end

            S_HOLD: begin
               if (if_id_write) begin
                  pc          <= hold_pc;
                  instruction <= hold_instr;
                  valid       <= 1'b1;
                  if (advance) begin
                     fetch_pc <= pc_plus4;
                  end
                  state <= S_FETCH;
               end
            end

            S_DRAIN: begin
               // Nothing real to deliver while the killed request drains; its data is dropped.
               if (if_id_write) begin
                  pc          <= '0;
                  instruction <= NOP_INSTR;
                  valid       <= 1'b0;
               end
               if (imem_ready) begin
                  state <= S_FETCH;
               end
            end

            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_top.sv
// Bench for fetch_top: a per-cycle stimulus table with a delivery scoreboard, plus a wrap-around sequence on a second instance.
// Latency: each row is driven at the falling edge and sampled 1 ns later; IF/ID reflects the rising edge that ended the previous row.
// Backpressure: stall rows use if_id_write/pc_write=0; the memory model answers any address combinationally.
module tb_fetch_top;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        iw;
      logic        pw;
      logic        br;
      logic [31:0] tgt;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evld;
      logic        hold;
      logic [31:0] pa;      // address delivered at this row's edge, 0 = none
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset, pc_write, if_id_write, branch, imem_ready;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, valid;
   logic [31:0] imem_addr, pc, instruction;

   logic        w_reset;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_rdata, w_pc, w_instr;

   int   checks;
   int   failures;
   vec_t vecs[$];
   exp_t sb[$];
   exp_t last;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   assign imem_rdata = mem_data(imem_addr);
   assign w_rdata    = mem_data(w_addr);

   fetch_top #(
      .ADDR_SIZE(32), .INSTR_SIZE(32), .RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
      .branch(branch), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc(pc), .instruction(instruction), .valid(valid)
   );

   fetch_top #(
      .ADDR_SIZE(32), .INSTR_SIZE(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)
   ) dut_w (
      .clk(clk), .reset(w_reset), .pc_write(1'b1), .if_id_write(1'b1),
      .branch(1'b0), .branch_target(32'h0),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(w_rdata),
      .pc(w_pc), .instruction(w_instr), .valid(w_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic rst, rdy, iw, pw, br, input logic [31:0] tgt,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evld, hold, input logic [31:0] pa);
      vec_t r;
      r.rst = rst; r.rdy = rdy; r.iw = iw; r.pw = pw; r.br = br; r.tgt = tgt;
      r.ereq = ereq; r.eaddr = eaddr; r.evld = evld; r.hold = hold; r.pa = pa;
      return r;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;

      //                 rst rdy iw pw br tgt           req addr          vld hold push
      // zero-wait memory from RESET_PC
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0100, 0, 0, 32'h0000_0100));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0104, 1, 0, 32'h0000_0104));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0108, 1, 0, 32'h0000_0108));
      // two wait states per access
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_010C, 1, 0, 32'h0));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_010C, 0, 0, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_010C, 0, 0, 32'h0000_010C));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0110, 1, 0, 32'h0));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0110, 0, 0, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0110, 0, 0, 32'h0000_0110));
      // branch while the response completes: data dropped, go straight to target
      vecs.push_back(v(0, 1, 1, 1, 1, 32'h0000_01FC, 1, 32'h0000_0114, 1, 0, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_01FC, 0, 0, 32'h0000_01FC));
      // decode stall starting on the 0x200 response
      vecs.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h0000_0200, 1, 0, 32'h0));
      vecs.push_back(v(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 1, 32'h0));
      vecs.push_back(v(0, 1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 1, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        0, 32'h0,         1, 1, 32'h0000_0200));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0204, 1, 0, 32'h0000_0204));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0208, 1, 0, 32'h0));
      // branch with 0x208 outstanding, memory answers two cycles later
      vecs.push_back(v(0, 0, 1, 1, 1, 32'h0000_0400, 1, 32'h0000_0208, 0, 0, 32'h0));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0208, 0, 0, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0208, 0, 0, 32'h0));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0400, 0, 0, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0400, 0, 0, 32'h0000_0400));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0404, 1, 0, 32'h0000_0404));
      // stall into HOLD, then branch with if_id_write still low
      vecs.push_back(v(0, 1, 0, 0, 0, 32'h0,        1, 32'h0000_0408, 1, 0, 32'h0));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h0000_0500, 0, 32'h0,         1, 1, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0500, 0, 0, 32'h0000_0500));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0504, 1, 0, 32'h0000_0504));
      // reset while draining a killed request
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0508, 1, 0, 32'h0));
      vecs.push_back(v(0, 0, 1, 1, 1, 32'h0000_0600, 1, 32'h0000_0508, 0, 0, 32'h0));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0508, 0, 0, 32'h0));
      vecs.push_back(v(1, 0, 1, 1, 0, 32'h0,        0, 32'h0,         0, 0, 32'h0));
      vecs.push_back(v(0, 1, 1, 1, 0, 32'h0,        1, 32'h0000_0100, 0, 0, 32'h0000_0100));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0104, 1, 0, 32'h0));
      vecs.push_back(v(0, 0, 1, 1, 0, 32'h0,        1, 32'h0000_0104, 0, 0, 32'h0));

      // reset state
      reset = 1'b1; w_reset = 1'b1;
      imem_ready = 1'b0; if_id_write = 1'b1; pc_write = 1'b1;
      branch = 1'b0; branch_target = 32'h0;
      last.pc = 32'h0; last.instr = NOP;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instruction, NOP);
      chk("rst_valid", {31'b0, valid}, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t r;
         r = vecs[i];
         @(negedge clk);
         reset = r.rst; imem_ready = r.rdy; if_id_write = r.iw; pc_write = r.pw;
         branch = r.br; branch_target = r.tgt;
         #1;
         chk($sformatf("req[%0d]", i), {31'b0, imem_req}, {31'b0, r.ereq});
         if (r.ereq) chk($sformatf("addr[%0d]", i), imem_addr, r.eaddr);
         chk($sformatf("valid[%0d]", i), {31'b0, valid}, {31'b0, r.evld});
         if (r.evld) begin
            if (r.hold) begin
               chk($sformatf("hold_pc[%0d]", i), pc, last.pc);
               chk($sformatf("hold_instr[%0d]", i), instruction, last.instr);
            end else if (sb.size() == 0) begin
               chk($sformatf("sb_empty[%0d]", i), 32'h1, 32'h0);
            end else begin
               last = sb.pop_front();
               chk($sformatf("ifid_pc[%0d]", i), pc, last.pc);
               chk($sformatf("ifid_instr[%0d]", i), instruction, last.instr);
            end
         end else begin
            chk($sformatf("bubble_instr[%0d]", i), instruction, NOP);
         end
         if (r.pa != 32'h0) begin
            exp_t e;
            e.pc = r.pa + 32'd4;
            e.instr = mem_data(r.pa);
            sb.push_back(e);
         end
      end
      chk("sb_drained", 32'(sb.size()), 32'h0);

      // wrap-around of the fetch PC
      @(negedge clk);
      w_reset = 1'b0;
      #1;
      chk("wrap_req", {31'b0, w_req}, 32'h1);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      #1;
      chk("wrap_addr1", w_addr, 32'h0);
      chk("wrap_valid", {31'b0, w_valid}, 32'h1);
      chk("wrap_pc0", w_pc, 32'h0);
      chk("wrap_instr0", w_instr, mem_data(32'hFFFF_FFFC));
      @(negedge clk);
      #1;
      chk("wrap_addr2", w_addr, 32'h4);
      chk("wrap_pc1", w_pc, 32'h4);
      chk("wrap_instr1", w_instr, mem_data(32'h0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
